// File: rtl/vedic_mac_pipe.sv
// Pipelined Vedic (split-operand) multiply-accumulate with group framing and valid/ready handshakes.
// Optional build macro SATURATE_EN: clamp the accumulator to all-ones on carry-out instead of wrapping.
module vedic_mac_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned H   = WIDTH / 2;
  localparam int unsigned P_W = 2 * WIDTH;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4 || ACC_W < 2 * WIDTH) begin : g_bad_param
      $error("vedic_mac_pipe: WIDTH must be even and >= 4, ACC_W must be >= 2*WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, OPEN} state_t;

  state_t             state_q, state_d;
  logic               v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
  logic [WIDTH-1:0]   a1_q, a1_d, b1_q, b1_d;
  logic               v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;
  logic [WIDTH-1:0]   pll_q, pll_d, plh_q, plh_d, phl_q, phl_d, phh_q, phh_d;
  logic               v3_q, v3_d, f3_q, f3_d, l3_q, l3_d;
  logic [P_W-1:0]     p3_q, p3_d;
  logic [ACC_W-1:0]   acc_q, acc_d, out_acc_q, out_acc_d;
  logic               ovf_q, ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
  logic               stall;
  logic [ACC_W:0]     sum;
  logic [H-1:0]       al, ah, bl, bh;

  always_comb begin
    stall    = out_valid_q & ~out_ready;
    in_ready = rst_n & ~stall;
    busy     = v1_q | v2_q | v3_q | (state_q == OPEN) | out_valid_q;
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

  // Next-state for the operand pipeline and the accumulator; everything holds on stall.
  always_comb begin
    state_d     = state_q;
    v1_d        = v1_q;
    f1_d        = f1_q;
    l1_d        = l1_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    v2_d        = v2_q;
    f2_d        = f2_q;
    l2_d        = l2_q;
    pll_d       = pll_q;
    plh_d       = plh_q;
    phl_d       = phl_q;
    phh_d       = phh_q;
    v3_d        = v3_q;
    f3_d        = f3_q;
    l3_d        = l3_q;
    p3_d        = p3_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    al          = a1_q[H-1:0];
    ah          = a1_q[WIDTH-1:H];
    bl          = b1_q[H-1:0];
    bh          = b1_q[WIDTH-1:H];
    sum         = {1'b0, acc_q} + (ACC_W + 1)'(p3_q);

    if (!stall) begin
      v1_d  = in_valid & in_ready;
      a1_d  = a;
      b1_d  = b;
      f1_d  = in_first;
      l1_d  = in_last;

      v2_d  = v1_q;
      f2_d  = f1_q;
      l2_d  = l1_q;
      pll_d = WIDTH'(al) * WIDTH'(bl);
      plh_d = WIDTH'(al) * WIDTH'(bh);
      phl_d = WIDTH'(ah) * WIDTH'(bl);
      phh_d = WIDTH'(ah) * WIDTH'(bh);

      v3_d  = v2_q;
      f3_d  = f2_q;
      l3_d  = l2_q;
      p3_d  = (P_W'(phh_q) << WIDTH) + ((P_W'(plh_q) + P_W'(phl_q)) << H) + P_W'(pll_q);

      out_valid_d = 1'b0;
      if (v3_q) begin
        if (state_q == IDLE || f3_q) begin
          acc_d = ACC_W'(p3_q);
          ovf_d = 1'b0;
        end else begin
`ifdef SATURATE_EN
          acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d = ovf_q | sum[ACC_W];
        end
        state_d = OPEN;
        if (l3_q) begin
          out_valid_d = 1'b1;
          out_acc_d   = acc_d;
          out_ovf_d   = ovf_d;
          state_d     = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      v2_q        <= 1'b0;
      f2_q        <= 1'b0;
      l2_q        <= 1'b0;
      pll_q       <= '0;
      plh_q       <= '0;
      phl_q       <= '0;
      phh_q       <= '0;
      v3_q        <= 1'b0;
      f3_q        <= 1'b0;
      l3_q        <= 1'b0;
      p3_q        <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      f1_q        <= f1_d;
      l1_q        <= l1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      v2_q        <= v2_d;
      f2_q        <= f2_d;
      l2_q        <= l2_d;
      pll_q       <= pll_d;
      plh_q       <= plh_d;
      phl_q       <= phl_d;
      phh_q       <= phh_d;
      v3_q        <= v3_d;
      f3_q        <= f3_d;
      l3_q        <= l3_d;
      p3_q        <= p3_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_vedic_mac_pipe.sv
// Self-checking bench for vedic_mac_pipe: 8/24 main instance with a result scoreboard,
// plus 8/16 (overflow / saturation) and 16/40 (wide one-term groups) instances.
module tb_vedic_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid, in_ready, in_first, in_last, out_valid, out_ready, out_ovf, busy;
  logic [7:0]  a, b;
  logic [23:0] out_acc;

  logic        in_valid_2, in_ready_2, in_first_2, in_last_2, out_valid_2, out_ready_2, out_ovf_2, busy_2;
  logic [7:0]  a_2, b_2;
  logic [15:0] out_acc_2;

  logic        in_valid_3, in_ready_3, in_first_3, in_last_3, out_valid_3, out_ready_3, out_ovf_3, busy_3;
  logic [15:0] a_3, b_3;
  logic [39:0] out_acc_3;

  vedic_mac_pipe #(.WIDTH(8), .ACC_W(24)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  vedic_mac_pipe #(.WIDTH(8), .ACC_W(16)) u_dut_2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_2), .in_ready(in_ready_2), .a(a_2), .b(b_2),
    .in_first(in_first_2), .in_last(in_last_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
    .out_acc(out_acc_2), .out_ovf(out_ovf_2), .busy(busy_2)
  );

  vedic_mac_pipe #(.WIDTH(16), .ACC_W(40)) u_dut_3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_3), .in_ready(in_ready_3), .a(a_3), .b(b_3),
    .in_first(in_first_3), .in_last(in_last_3), .out_valid(out_valid_3), .out_ready(out_ready_3),
    .out_acc(out_acc_3), .out_ovf(out_ovf_3), .busy(busy_3)
  );

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        f;
    logic        l;
    logic [23:0] acc;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[14];
  int          total = 0;
  int          bad = 0;
  int          hold_cnt = 0;
  logic [23:0] hold_acc = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: backpressure checks, then scoreboard pop for a result the next edge will hand over.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (hold_cnt > 0 && out_valid && !out_ready) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_acc", 64'(out_acc), 64'(hold_acc));
      hold_cnt--;
      if (hold_cnt == 0) out_ready = 1'b1;
    end
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_result: got acc=%0d with nothing expected", out_acc);
      end else begin
        e = sbq.pop_front();
        check("sb_acc", 64'(out_acc), 64'(e.acc));
        check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tbv, input logic f, input logic l,
                      input logic [23:0] ea, input logic eo);
    exp_t e;
    bit   took;
    took = 1'b0;
    a = ta; b = tbv; in_first = f; in_last = l; in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (in_ready) begin
        took = 1'b1;
        break;
      end
      cyc();
    end
    if (!took) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end else begin
      if (l) begin
        e.acc = ea;
        e.ovf = eo;
        sbq.push_back(e);
      end
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending results busy=%0d expected 0", sbq.size(), busy);
    end
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_valid_2 = 1'b0; a_2 = '0; b_2 = '0; in_first_2 = 1'b0; in_last_2 = 1'b0; out_ready_2 = 1'b1;
    in_valid_3 = 1'b0; a_3 = '0; b_3 = '0; in_first_3 = 1'b0; in_last_3 = 1'b0; out_ready_3 = 1'b1;

    tbl[0]  = '{8'd3,   8'd5,   1'b1, 1'b0, 24'd0,     1'b0};
    tbl[1]  = '{8'd7,   8'd11,  1'b0, 1'b0, 24'd0,     1'b0};
    tbl[2]  = '{8'd200, 8'd100, 1'b0, 1'b0, 24'd0,     1'b0};
    tbl[3]  = '{8'd255, 8'd1,   1'b0, 1'b1, 24'd20347, 1'b0};
    tbl[4]  = '{8'd2,   8'd2,   1'b0, 1'b0, 24'd0,     1'b0};
    tbl[5]  = '{8'd3,   8'd3,   1'b0, 1'b1, 24'd13,    1'b0};
    tbl[6]  = '{8'd100, 8'd100, 1'b1, 1'b0, 24'd0,     1'b0};
    tbl[7]  = '{8'd9,   8'd9,   1'b1, 1'b1, 24'd81,    1'b0};
    tbl[8]  = '{8'd255, 8'd0,   1'b1, 1'b1, 24'd0,     1'b0};
    tbl[9]  = '{8'd128, 8'd128, 1'b1, 1'b1, 24'd16384, 1'b0};
    tbl[10] = '{8'd15,  8'd15,  1'b1, 1'b1, 24'd225,   1'b0};
    tbl[11] = '{8'd16,  8'd16,  1'b1, 1'b0, 24'd0,     1'b0};
    tbl[12] = '{8'd1,   8'd255, 1'b0, 1'b1, 24'd511,   1'b0};
    tbl[13] = '{8'd170, 8'd85,  1'b1, 1'b1, 24'd14450, 1'b0};

    cyc();
    cyc();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", 64'(out_acc), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    cyc();

    // Single full-scale term and its three-edge latency.
    send(8'd255, 8'd255, 1'b1, 1'b1, 24'd65025, 1'b0);
    check("lat_edge0", 64'(out_valid), 64'd0);
    cyc();
    check("lat_edge1", 64'(out_valid), 64'd0);
    cyc();
    check("lat_edge2", 64'(out_valid), 64'd0);
    cyc();
    check("lat_edge3", 64'(out_valid), 64'd1);
    drain();

    for (int i = 0; i < 14; i++)
      send(tbl[i].va, tbl[i].vb, tbl[i].f, tbl[i].l, tbl[i].acc, tbl[i].ovf);
    drain();

    // Backpressure: first result held while the next group queues up behind it.
    out_ready = 1'b0;
    hold_cnt  = 4;
    hold_acc  = 24'd500;
    send(8'd10, 8'd10, 1'b1, 1'b0, 24'd0, 1'b0);
    send(8'd20, 8'd20, 1'b0, 1'b1, 24'd500, 1'b0);
    send(8'd1, 8'd1, 1'b1, 1'b0, 24'd0, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b0, 24'd0, 1'b0);
    send(8'd3, 8'd3, 1'b0, 1'b0, 24'd0, 1'b0);
    send(8'd4, 8'd4, 1'b0, 1'b0, 24'd0, 1'b0);
    send(8'd5, 8'd5, 1'b0, 1'b1, 24'd55, 1'b0);
    check("hold_released", 64'(hold_cnt), 64'd0);
    drain();

    // Reset in the middle of an open group.
    send(8'd4, 8'd4, 1'b1, 1'b0, 24'd0, 1'b0);
    send(8'd5, 8'd5, 1'b0, 1'b0, 24'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_acc", 64'(out_acc), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    send(8'd2, 8'd3, 1'b1, 1'b1, 24'd6, 1'b0);
    drain();

    // ACC_W=16: two 255*255 terms overflow the accumulator.
    in_valid_2 = 1'b1; a_2 = 8'd255; b_2 = 8'd255; in_first_2 = 1'b1; in_last_2 = 1'b0;
    #1;
    check("ovf_in_ready", 64'(in_ready_2), 64'd1);
    cyc();
    in_first_2 = 1'b0; in_last_2 = 1'b1;
    cyc();
    in_valid_2 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_2) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    check("ovf_valid", 64'(got), 64'd1);
`ifdef SATURATE_EN
    check("ovf_acc", 64'(out_acc_2), 64'd65535);
`else
    check("ovf_acc", 64'(out_acc_2), 64'd64514);
`endif
    check("ovf_flag", 64'(out_ovf_2), 64'd1);
    cyc();

    // WIDTH=16: back-to-back one-term groups give back-to-back results.
    in_valid_3 = 1'b1; a_3 = 16'd65535; b_3 = 16'd65535; in_first_3 = 1'b1; in_last_3 = 1'b1;
    cyc();
    a_3 = 16'd1234; b_3 = 16'd5678;
    cyc();
    in_valid_3 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_3) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    check("w16_valid0", 64'(got), 64'd1);
    check("w16_acc0", 64'(out_acc_3), 64'd4294836225);
    cyc();
    check("w16_valid1", 64'(out_valid_3), 64'd1);
    check("w16_acc1", 64'(out_acc_3), 64'd7006652);
    check("w16_ovf1", 64'(out_ovf_3), 64'd0);
    cyc();
    check("w16_valid2", 64'(out_valid_3), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vedic_mac_pipe.md
Name: vedic_mac_pipe

Overview:
Parametrised, pipelined multiply-accumulate unit built on the team's Vedic (Urdhva-Tiryagbhyam) split-operand decomposition. It generalises the fixed 8x8 combinational Vedic multiplier to any even operand width, and adds operand pipelining, a wide accumulator with group framing, valid/ready handshakes and overflow reporting. It sits between the operand input interface and the result output path of the MAC datapath.

Parameters:
WIDTH, 8, operand width in bits; must be even and at least 4.
ACC_W, 24, accumulator and result width; must be at least 2*WIDTH. Violating either rule is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  unsigned multiplicand
b  input  WIDTH  unsigned multiplier
in_first  input  1  term opens a new accumulation group
in_last  input  1  term closes the group
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_acc  output  ACC_W  accumulated group result
out_ovf  output  1  group overflowed ACC_W
busy  output  1  any term in flight or group open

Behaviour:
- Reset: synchronous, applied when rst_n=0 at a clk edge. All pipeline valid bits, the accumulator, the group-open flag, out_valid, out_acc and out_ovf clear to 0. in_ready=0 while rst_n=0. Reset mid-group discards the partial sum and any in-flight terms.
- Handshake:
  - An operand pair is accepted when in_valid and in_ready are both 1.
  - stall = out_valid and not out_ready.
  - in_ready = rst_n and not stall.
  - While stall=1, every pipeline register, the accumulator and the outputs hold.
- Pipeline (3 stages, throughput 1 term/cycle):
  - S1: registers a, b, in_first and in_last.
  - S2: splits each operand into high and low halves of WIDTH/2 bits, then registers four half-width products: PLL=AL*BL, PLH=AL*BH, PHL=AH*BL, PHH=AH*BH, each WIDTH bits wide.
  - S3: forms P = (PHH<<WIDTH) + ((PLH+PHL)<<WIDTH/2) + PLL. P is exact, 2*WIDTH bits, zero-extended to ACC_W. P is then accumulated.
- Accumulator FSM:
  - IDLE: no group open. The next term starts a group whether or not in_first is set: acc=P, ovf=0, and the state moves to OPEN.
  - OPEN: if in_first=1 on the term, the group restarts (acc=P, ovf=0; the previous partial sum is dropped). Otherwise acc=acc+P modulo 2^ACC_W, and ovf is set sticky if the add carries out of ACC_W.
  - Any term with in_last=1 loads out_acc and out_ovf with the post-update values, sets out_valid=1 and returns the FSM to IDLE. A term with in_first=1 and in_last=1 together is a one-term group.
- Latency: a term accepted at edge N with in_last=1 gives out_valid=1 after edge N+3.
- Output:
  - out_acc and out_ovf stay stable while out_valid=1 and out_ready=0.
  - out_valid clears on the edge where out_ready=1 and no new last-term completes that edge.
  - If a new last-term completes in the same edge the old result is accepted, the new result replaces it and out_valid stays 1.
- busy = any stage valid bit set, or FSM in OPEN, or out_valid=1.

Optional Feature:
SATURATE_EN. When defined, an accumulate that would carry out of ACC_W clamps acc to all-ones instead of wrapping. Later terms in the same group keep it clamped, and ovf is still set. When undefined, the accumulator wraps modulo 2^ACC_W. out_ovf behaves identically in both builds.

Test Plan:
1. WIDTH=8: a=255, b=255, in_first=1, in_last=1 -> out_valid 3 cycles after accept, out_acc=65025 (0xFE01), out_ovf=0.
2. One 4-term group (3*5, 7*11, 200*100, 255*1) issued back-to-back -> single result out_acc=20347, exactly one out_valid pulse.
3. ACC_W=16, group of 255*255 twice -> out_acc=64514, out_ovf=1. With SATURATE_EN defined -> out_acc=65535, out_ovf=1.
4. Backpressure: out_ready=0 with a result pending and a second group in flight -> in_ready=0, out_acc stable, no terms lost. Then set out_ready=1 -> first result accepted, second result follows with the correct value.
5. Reset mid-group: after 2 terms, drive rst_n=0 for 1 cycle -> out_valid=0, out_acc=0, busy=0. Then a one-term group 2*3 -> out_acc=6.
6. WIDTH=16, ACC_W=40: in_first=1 and in_last=1 on every cycle with out_ready=1, operands 65535*65535 then 1234*5678 -> out_valid on consecutive cycles with values 4294836225 then 7006652.
